// File: rtl/ct_idu_is_pkg.sv
// Shared defaults and index helper for the AIQ launch-ready tracker.
// No timing, no flow control: constants and a pure function only.
package ct_idu_is_pkg;

  localparam int DEF_NUM_CREATE = 2;
  localparam int DEF_NUM_SRC    = 3;
  localparam int DEF_CNT_W      = 3;

  // Flat bit position of (create port k, source s) in y_create_src_match.
  function automatic int src_match_idx(input int k, input int s, input int num_src);
    return k * num_src + s;
  endfunction

endpackage

// File: rtl/ct_idu_is_aiq_lch_rdy_n_if.sv
// Create/wake/cancel inputs and read-port outputs of one AIQ entry tracker.
// Pure wiring bundle; no handshake, every input is sampled each cycle.
interface ct_idu_is_aiq_lch_rdy_n_if
  import ct_idu_is_pkg::*;
#(
  parameter int NUM_CREATE = DEF_NUM_CREATE,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int CNT_W      = DEF_CNT_W
);

  logic                          vld;
  logic                          x_create_dp_en;
  logic [NUM_SRC-1:0]            x_create_lch_rdy;
  logic [NUM_CREATE-1:0]         x_create_entry;
  logic [NUM_CREATE-1:0]         y_create_dp_en;
  logic [NUM_CREATE*NUM_SRC-1:0] y_create_src_match;
  logic                          y_wake_vld;
  logic [NUM_SRC-1:0]            y_wake_src_match;
  logic [CNT_W-1:0]              y_wake_lat;
  logic                          y_cancel;
  logic [NUM_SRC-1:0]            x_read_lch_rdy;
  logic                          x_read_all_rdy;
  logic [NUM_SRC-1:0]            x_read_pend;

  modport master (
    output vld, x_create_dp_en, x_create_lch_rdy, x_create_entry,
           y_create_dp_en, y_create_src_match,
           y_wake_vld, y_wake_src_match, y_wake_lat, y_cancel,
    input  x_read_lch_rdy, x_read_all_rdy, x_read_pend
  );

  modport slave (
    input  vld, x_create_dp_en, x_create_lch_rdy, x_create_entry,
           y_create_dp_en, y_create_src_match,
           y_wake_vld, y_wake_src_match, y_wake_lat, y_cancel,
    output x_read_lch_rdy, x_read_all_rdy, x_read_pend
  );

endinterface

// File: rtl/ct_idu_is_lch_rdy_src.sv
// One source operand: launch-ready bit plus wake countdown, 1-cycle update.
// No backpressure; cancel/create/wake resolved by fixed priority each cycle.
module ct_idu_is_lch_rdy_src
  import ct_idu_is_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             y_clk,
  input  logic             cpurst,
  input  logic             vld,
  input  logic             create_en,
  input  logic             create_rdy,
  input  logic             cancel,
  input  logic             cre_any,
  input  logic             cre_rdy,
  input  logic             wake,
  input  logic [CNT_W-1:0] wake_lat,
  output logic             lch_rdy,
  output logic             pend
);

  logic             rdy_q, rdy_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             cnt_run;

  assign cnt_run = (cnt_q != '0);

  always_comb begin
    rdy_nxt = rdy_q;
    cnt_nxt = cnt_q;
    if (create_en) begin
      rdy_nxt = create_rdy;
      cnt_nxt = '0;
    end else if (vld) begin
      if (cancel && cnt_run) begin
        rdy_nxt = 1'b0;
        cnt_nxt = '0;
      end else if (cre_any) begin
        // Sibling create overrides the ready bit; the countdown keeps ticking.
        rdy_nxt = cre_rdy;
        if (cnt_run) cnt_nxt = cnt_q - CNT_W'(1);
      end else if (wake) begin
        if (wake_lat == '0) begin
          rdy_nxt = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = wake_lat;
        end
      end else if (cnt_run) begin
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) rdy_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge y_clk) begin
    if (cpurst) begin
      rdy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rdy_q <= rdy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign lch_rdy = rdy_q;
  assign pend    = cnt_run;

endmodule

// File: rtl/ct_idu_is_aiq_lch_rdy_n.sv
// Per-entry AIQ launch-ready tracker: registered state 1 cycle, create bypass 0 cycles.
// No backpressure; outputs forced to zero while cpurst is high.
module ct_idu_is_aiq_lch_rdy_n
  import ct_idu_is_pkg::*;
#(
  parameter int NUM_CREATE = DEF_NUM_CREATE,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                     y_clk,
  input  logic                     cpurst,
  ct_idu_is_aiq_lch_rdy_n_if.slave aiq
);

  logic [NUM_CREATE-1:0] cre_en;
  logic                  cre_any;
  logic                  cre_one;
  logic [NUM_SRC-1:0]    cre_rdy;
  logic [NUM_SRC-1:0]    port_match [NUM_CREATE];
  logic [NUM_SRC-1:0]    lch_rdy_q;
  logic [NUM_SRC-1:0]    pend_q;
  logic [NUM_SRC-1:0]    rd_rdy;

  for (genvar k = 0; k < NUM_CREATE; k++) begin : g_port
    assign port_match[k] = aiq.y_create_src_match[src_match_idx(k, 0, NUM_SRC) +: NUM_SRC];
  end

  // Lowest active create port wins; with exactly one active it is also the bypass source.
  always_comb begin
    cre_en  = aiq.y_create_dp_en & aiq.x_create_entry;
    cre_any = |cre_en;
    cre_one = cre_any && ((cre_en & (cre_en - NUM_CREATE'(1))) == '0);
    cre_rdy = '0;
    for (int k = NUM_CREATE - 1; k >= 0; k--) begin
      if (cre_en[k]) cre_rdy = port_match[k];
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    ct_idu_is_lch_rdy_src #(
      .CNT_W (CNT_W)
    ) u_src (
      .y_clk      (y_clk),
      .cpurst     (cpurst),
      .vld        (aiq.vld),
      .create_en  (aiq.x_create_dp_en),
      .create_rdy (aiq.x_create_lch_rdy[s]),
      .cancel     (aiq.y_cancel),
      .cre_any    (cre_any),
      .cre_rdy    (cre_rdy[s]),
      .wake       (aiq.y_wake_vld & aiq.y_wake_src_match[s]),
      .wake_lat   (aiq.y_wake_lat),
      .lch_rdy    (lch_rdy_q[s]),
      .pend       (pend_q[s])
    );
  end

  assign rd_rdy             = cre_one ? cre_rdy : lch_rdy_q;
  assign aiq.x_read_lch_rdy = cpurst ? '0 : rd_rdy;
  assign aiq.x_read_all_rdy = ~cpurst & (&rd_rdy);
  assign aiq.x_read_pend    = cpurst ? '0 : pend_q;

endmodule

// File: tb/tb_ct_idu_is_aiq_lch_rdy_n.sv
// Directed scenarios then random traffic, checked against a deadline-based model.
module tb_ct_idu_is_aiq_lch_rdy_n;

  localparam int NC = 2;
  localparam int NS = 3;
  localparam int CW = 3;

  logic y_clk;
  logic cpurst;

  ct_idu_is_aiq_lch_rdy_n_if #(.NUM_CREATE(NC), .NUM_SRC(NS), .CNT_W(CW)) aiq ();

  ct_idu_is_aiq_lch_rdy_n #(.NUM_CREATE(NC), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .y_clk  (y_clk),
    .cpurst (cpurst),
    .aiq    (aiq)
  );

  initial y_clk = 1'b0;
  always #5 y_clk = ~y_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: ready bit per source plus absolute cycle at which a countdown completes (0 = none).
  bit m_rdy [NS];
  int m_due [NS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
  endtask

  task automatic peek(input string tag, input logic [NS-1:0] rd, input logic [NS-1:0] pd, input logic al);
    #1;
    chk({tag, "_rd"},   32'(aiq.x_read_lch_rdy), 32'(rd));
    chk({tag, "_pend"}, 32'(aiq.x_read_pend),    32'(pd));
    chk({tag, "_all"},  32'(aiq.x_read_all_rdy), 32'(al));
  endtask

  // Check outputs against the model for the current cycle, advance the model, cross the edge.
  task automatic step();
    logic [NC-1:0] ce;
    logic [NS-1:0] sel, exp_rd, exp_pd;
    int            nset;
    bit            found;
    @(negedge y_clk);
    ce    = aiq.y_create_dp_en & aiq.x_create_entry;
    nset  = 0;
    found = 0;
    sel   = '0;
    for (int k = 0; k < NC; k++) begin
      if (ce[k]) begin
        nset++;
        if (!found) begin
          for (int s = 0; s < NS; s++) sel[s] = aiq.y_create_src_match[k*NS+s];
          found = 1;
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      exp_rd[s] = cpurst ? 1'b0 : ((nset == 1) ? sel[s] : m_rdy[s]);
      exp_pd[s] = cpurst ? 1'b0 : (m_due[s] != 0);
    end
    chk("m_rd",   32'(aiq.x_read_lch_rdy), 32'(exp_rd));
    chk("m_pend", 32'(aiq.x_read_pend),    32'(exp_pd));
    chk("m_all",  32'(aiq.x_read_all_rdy), 32'(exp_rd == '1));

    for (int s = 0; s < NS; s++) begin
      if (cpurst) begin
        m_rdy[s] = 0; m_due[s] = 0;
      end else if (aiq.x_create_dp_en) begin
        m_rdy[s] = aiq.x_create_lch_rdy[s]; m_due[s] = 0;
      end else if (!aiq.vld) begin
        if (m_due[s] != 0) m_due[s] = m_due[s] + 1;   // frozen countdown slips a cycle
      end else if (aiq.y_cancel && m_due[s] != 0) begin
        m_rdy[s] = 0; m_due[s] = 0;
      end else if (nset != 0) begin
        m_rdy[s] = sel[s];
        if (m_due[s] == cyc + 1) m_due[s] = 0;
      end else if (aiq.y_wake_vld && aiq.y_wake_src_match[s]) begin
        if (aiq.y_wake_lat == 0) begin
          m_rdy[s] = 1; m_due[s] = 0;
        end else begin
          m_due[s] = cyc + 1 + int'(aiq.y_wake_lat);
        end
      end else if (m_due[s] == cyc + 1) begin
        m_rdy[s] = 1; m_due[s] = 0;
      end
    end
    @(posedge y_clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    aiq.x_create_dp_en     = 1'b0;
    aiq.x_create_lch_rdy   = '0;
    aiq.x_create_entry     = '0;
    aiq.y_create_dp_en     = '0;
    aiq.y_create_src_match = '0;
    aiq.y_wake_vld         = 1'b0;
    aiq.y_wake_src_match   = '0;
    aiq.y_wake_lat         = '0;
    aiq.y_cancel           = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin m_rdy[s] = 0; m_due[s] = 0; end
    cpurst  = 1'b1;
    aiq.vld = 1'b0;
    idle();
    #1;
    step();
    step();
    cpurst = 1'b0;
    peek("reset", 3'b000, 3'b000, 1'b0);

    // Create with 101
    aiq.x_create_dp_en   = 1'b1;
    aiq.x_create_lch_rdy = 3'b101;
    step();
    idle();
    aiq.vld = 1'b1;
    peek("create", 3'b101, 3'b000, 1'b0);

    // Two sibling creates: no bypass, port 0 wins next cycle
    aiq.x_create_entry     = 2'b11;
    aiq.y_create_dp_en     = 2'b11;
    aiq.y_create_src_match = 6'b111_000;
    peek("dual_byp", 3'b101, 3'b000, 1'b0);
    step();
    idle();
    peek("dual_reg", 3'b000, 3'b000, 1'b0);

    // Single port-1 create: bypass same cycle, registered next
    aiq.x_create_entry     = 2'b11;
    aiq.y_create_dp_en     = 2'b10;
    aiq.y_create_src_match = 6'b010_000;
    peek("p1_byp", 3'b010, 3'b000, 1'b0);
    step();
    idle();
    peek("p1_reg", 3'b010, 3'b000, 1'b0);

    // Wake src1 lat=3 with src0/src2 ready
    aiq.x_create_dp_en   = 1'b1;
    aiq.x_create_lch_rdy = 3'b101;
    step();
    idle();
    aiq.y_wake_vld       = 1'b1;
    aiq.y_wake_src_match = 3'b010;
    aiq.y_wake_lat       = 3'd3;
    peek("wk_t0", 3'b101, 3'b000, 1'b0);
    step();
    idle();
    for (int i = 1; i <= 3; i++) begin
      peek($sformatf("wk_t%0d", i), 3'b101, 3'b010, 1'b0);
      step();
    end
    peek("wk_t4", 3'b111, 3'b000, 1'b1);

    // Wake src2 lat=4, cancel two cycles later
    aiq.x_create_dp_en   = 1'b1;
    aiq.x_create_lch_rdy = 3'b000;
    step();
    idle();
    aiq.y_wake_vld       = 1'b1;
    aiq.y_wake_src_match = 3'b100;
    aiq.y_wake_lat       = 3'd4;
    step();
    idle();
    step();
    aiq.y_cancel = 1'b1;
    peek("cn_t2", 3'b000, 3'b100, 1'b0);
    step();
    idle();
    peek("cn_t3", 3'b000, 3'b000, 1'b0);
    repeat (5) step();
    peek("cn_t8", 3'b000, 3'b000, 1'b0);

    // Reset during a lat=5 countdown
    aiq.y_wake_vld       = 1'b1;
    aiq.y_wake_src_match = 3'b001;
    aiq.y_wake_lat       = 3'd5;
    step();
    idle();
    cpurst = 1'b1;
    peek("rs_t1", 3'b000, 3'b000, 1'b0);
    step();
    cpurst = 1'b0;
    peek("rs_t2", 3'b000, 3'b000, 1'b0);
    repeat (8) step();
    peek("rs_t10", 3'b000, 3'b000, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cpurst                 = ($urandom_range(0, 199) == 0);
      aiq.vld                = ($urandom_range(0, 9) != 0);
      aiq.x_create_dp_en     = ($urandom_range(0, 24) == 0);
      aiq.x_create_lch_rdy   = NS'($urandom);
      aiq.x_create_entry     = NC'($urandom);
      aiq.y_create_dp_en     = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
      aiq.y_create_src_match = (NC*NS)'($urandom);
      aiq.y_wake_vld         = ($urandom_range(0, 2) == 0);
      aiq.y_wake_src_match   = NS'($urandom);
      aiq.y_wake_lat         = CW'($urandom);
      aiq.y_cancel           = ($urandom_range(0, 14) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
